edac_err_monitor: RTL

//  Parametrised synthesizable timing-error monitor for EDAC-instrumented cores (e.g. RISCV err_o).

---
 rtl/edac_mon_pkg.sv | 36 +++
 rtl/edac_prio_enc.sv | 27 ++
 rtl/edac_err_monitor.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/edac_mon_pkg.sv
// Package shared by the EDAC error monitor.
// Contents:
//   - Window FSM state encodings. The plain logic constants are used by the
//     RTL. The enum names the same encodings.
//   - grp_w():   width of one channel group. It rounds up, so the last group
//                may be short.
//   - sat_inc(): saturating +1 for counters up to 32 bits wide.
package edac_mon_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } mon_state_e;

    // Bits per channel group: ceil(err_w / groups).
    function automatic int unsigned grp_w(input int unsigned err_w, input int unsigned groups);
        return (err_w + groups - 1) / groups;
    endfunction

    // Add one when inc is set, but never step past max_value.
    // Counters wider than 32 bits are not supported by this helper.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic        inc,
                                            input logic [31:0] max_value);
        if (inc && (value < max_value)) begin
            return value + 32'd1;
        end
        return value;
    endfunction

endpackage

// File: rtl/edac_prio_enc.sv
// Combinational lowest-set-bit encoder.
// Ports:
//   vec_i  in   W      vector to encode
//   vld_o  out  1      at least one bit of vec_i is set
//   idx_o  out  IDX_W  index of the lowest set bit (0 when vld_o = 0)
module edac_prio_enc #(
    parameter int W     = 8,
    parameter int IDX_W = 3
) (
    input  logic [W-1:0]     vec_i,
    output logic             vld_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top down, so the last match wins. That match is the
    // lowest set bit.
    always_comb begin
        vld_o = |vec_i;
        idx_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/edac_err_monitor.sv
// Timing-error monitor for EDAC-instrumented cores.
//
// The module registers the raw error vector. It counts error cycles in total
// and for each contiguous channel group, using saturating counters. It also
// measures error cycles over a programmable window, raises a sticky alarm when
// a window reaches the threshold, and records the lowest failing bit of the
// first erroneous sample.
//
// Ports:
//   clk           in   1             rising-edge clock
//   rst_n         in   1             asynchronous active-low reset
//   err_i         in   ERR_W         raw error flags (held by the EDAC cells)
//   en_i          in   1             monitor enable
//   clr_i         in   1             synchronous clear of all monitor state
//   win_len_i     in   WIN_W         window length in cycles (0 behaves as 1)
//   thresh_i      in   CNT_W         alarm threshold, error cycles per window
//   total_cnt_o   out  CNT_W         cycles with any error since clear
//   grp_cnt_o     out  GROUPS*CNT_W  per-group error-cycle counts, group 0 in LSBs
//   win_cnt_o     out  CNT_W         error-cycle count of the last completed window
//   win_done_o    out  1             one-cycle pulse when win_cnt_o updates
//   alarm_o       out  1             sticky: a completed window reached thresh_i
//   first_vld_o   out  1             first error has been recorded
//   first_idx_o   out  IDX_W         lowest set bit of the first erroneous sample
//
// Latency: err_i sampled at edge t reaches the counters at edge t+1.
// All outputs come straight from registers.
module edac_err_monitor
    import edac_mon_pkg::*;
#(
    parameter int ERR_W  = 269,
    parameter int GROUPS = 4,
    parameter int CNT_W  = 16,
    parameter int WIN_W  = 12,
    parameter int IDX_W  = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ERR_W-1:0]         err_i,
    input  logic                     en_i,
    input  logic                     clr_i,
    input  logic [WIN_W-1:0]         win_len_i,
    input  logic [CNT_W-1:0]         thresh_i,
    output logic [CNT_W-1:0]         total_cnt_o,
    output logic [GROUPS*CNT_W-1:0]  grp_cnt_o,
    output logic [CNT_W-1:0]         win_cnt_o,
    output logic                     win_done_o,
    output logic                     alarm_o,
    output logic                     first_vld_o,
    output logic [IDX_W-1:0]         first_idx_o
);

    localparam int               GW       = grp_w(ERR_W, GROUPS);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WIN_W-1:0] ONE_CYC  = WIN_W'(1);
    localparam logic [WIN_W:0]   LAST_OFS = (WIN_W+1)'(2);

    // ------------------------------------------------------------------
    // Stage 1: sample the error vector. A disabled or cleared monitor
    // sees an all-zero sample.
    // ------------------------------------------------------------------
    logic [ERR_W-1:0] err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (clr_i || !en_i) begin
            err_q <= '0;
        end else begin
            err_q <= err_i;
        end
    end

    logic             err_any;
    logic [IDX_W-1:0] enc_idx;

    edac_prio_enc #(
        .W     (ERR_W),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .vec_i (err_q),
        .vld_o (err_any),
        .idx_o (enc_idx)
    );

    // ------------------------------------------------------------------
    // Stage 2: lifetime counters, one increment per cycle per source.
    // ------------------------------------------------------------------
    logic [GROUPS-1:0] grp_hit;

    for (genvar gi = 0; gi < GROUPS; gi++) begin : g_grp
        localparam int LO = gi * GW;
        localparam int HI = (LO + GW > ERR_W) ? ERR_W - 1 : LO + GW - 1;

        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // When GROUPS does not divide evenly, trailing groups can fall past
        // the vector end. Such groups never count.
        if (LO < ERR_W) begin : g_hit
            assign grp_hit[gi] = |err_q[HI:LO];
        end else begin : g_empty
            assign grp_hit[gi] = 1'b0;
        end

        always_comb begin
            cnt_d = CNT_W'(sat_inc(32'(cnt_q), grp_hit[gi], 32'(CNT_MAX)));
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (clr_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign grp_cnt_o[gi*CNT_W +: CNT_W] = cnt_q;
    end

    logic [CNT_W-1:0] total_q;
    logic [CNT_W-1:0] total_d;

    always_comb begin
        total_d = CNT_W'(sat_inc(32'(total_q), err_any, 32'(CNT_MAX)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q <= '0;
        end else if (clr_i) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    // ------------------------------------------------------------------
    // First-error record
    // ------------------------------------------------------------------
    logic             first_vld_q;
    logic [IDX_W-1:0] first_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_vld_q <= 1'b0;
            first_idx_q <= '0;
        end else if (clr_i) begin
            first_vld_q <= 1'b0;
            first_idx_q <= '0;
        end else if (!first_vld_q && err_any) begin
            first_vld_q <= 1'b1;
            first_idx_q <= enc_idx;
        end
    end

    // ------------------------------------------------------------------
    // Window FSM
    //
    // Each window is exactly len_q samples of err_q, and DONE is the last
    // of them. cyc_q counts the samples accumulated in RUN. RUN hands over
    // to DONE in the cycle where the counter reaches len_q-1. DONE restarts
    // the counter and accumulator, so the next window begins with no gap.
    // The window length is latched only when a window starts.
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [WIN_W-1:0] cyc_q, cyc_d;
    logic [WIN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic             done_q, done_d;
    logic             alarm_q, alarm_d;

    logic [WIN_W-1:0] len_eff;
    logic [CNT_W-1:0] acc_inc;
    logic             last_run;

    assign len_eff  = (win_len_i == '0) ? ONE_CYC : win_len_i;
    assign acc_inc  = CNT_W'(sat_inc(32'(acc_q), err_any, 32'(CNT_MAX)));
    assign last_run = (({1'b0, cyc_q} + LAST_OFS) == {1'b0, len_q});

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        len_d     = len_q;
        acc_d     = acc_q;
        win_cnt_d = win_cnt_q;
        done_d    = 1'b0;
        alarm_d   = alarm_q;

        if (clr_i) begin
            state_d   = ST_IDLE;
            cyc_d     = '0;
            acc_d     = '0;
            win_cnt_d = '0;
            alarm_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cyc_d = '0;
                    acc_d = '0;
                    if (en_i) begin
                        len_d   = len_eff;
                        // A one-cycle window has only its final sample.
                        state_d = (len_eff == ONE_CYC) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!en_i) begin
                        // Discard the partial window; win_cnt_q holds its value.
                        state_d = ST_IDLE;
                        cyc_d   = '0;
                        acc_d   = '0;
                    end else begin
                        acc_d = acc_inc;
                        cyc_d = cyc_q + ONE_CYC;
                        if (last_run) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    win_cnt_d = acc_inc;
                    done_d    = 1'b1;
                    if (acc_inc >= thresh_i) begin
                        alarm_d = 1'b1;
                    end
                    cyc_d = '0;
                    acc_d = '0;
                    if (en_i) begin
                        len_d   = len_eff;
                        state_d = (len_eff == ONE_CYC) ? ST_DONE : ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cyc_d   = '0;
                    acc_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cyc_q     <= '0;
            len_q     <= ONE_CYC;
            acc_q     <= '0;
            win_cnt_q <= '0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            len_q     <= len_d;
            acc_q     <= acc_d;
            win_cnt_q <= win_cnt_d;
            done_q    <= done_d;
            alarm_q   <= alarm_d;
        end
    end

    assign total_cnt_o = total_q;
    assign win_cnt_o   = win_cnt_q;
    assign win_done_o  = done_q;
    assign alarm_o     = alarm_q;
    assign first_vld_o = first_vld_q;
    assign first_idx_o = first_idx_q;

endmodule
